// File: rtl/polar_clip_mul_pkg.sv
// Shared constants, defaults and result record for the polar-clip shared multiplier.
package polar_clip_mul_pkg;

   localparam int OP_W        = 16;
   localparam int PROD_W      = 32;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ID_W    = 2;
   localparam int DEF_MUL_LAT = 3;

   typedef struct packed {
      logic                valid;
      logic [DEF_ID_W-1:0] id;
      logic [PROD_W-1:0]   data;
   } mul_res_t;

   // Round-robin successor of idx among n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/polar_clip_mul_if.sv
// Requester operand bus and tagged result stream of the shared multiplier.
interface polar_clip_mul_if
   import polar_clip_mul_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = DEF_ID_W
);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*OP_W-1:0] req_a;
   logic [NUM_REQ*OP_W-1:0] req_b;
   logic                    res_valid;
   logic                    res_ready;
   logic [PROD_W-1:0]       res_data;
   logic [ID_W-1:0]         res_id;

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_id
   );

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

endinterface

// File: rtl/polar_clip_mul_pipe.sv
// Signed 16x16 multiplier with MUL_LAT clock-enabled register stages (input, product, output).
module polar_clip_mul_pipe
   import polar_clip_mul_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic                     clk,
   input  logic                     ce,
   input  logic signed [OP_W-1:0]   a,
   input  logic signed [OP_W-1:0]   b,
   output logic signed [PROD_W-1:0] p
);

   logic signed [OP_W-1:0]   a_reg;
   logic signed [OP_W-1:0]   b_reg;
   logic signed [PROD_W-1:0] stage_reg [MUL_LAT-1];

   // No reset on the datapath so the registers fold into the DSP slice.
   always_ff @(posedge clk) begin
      if (ce) begin
         a_reg        <= a;
         b_reg        <= b;
         stage_reg[0] <= PROD_W'(a_reg) * PROD_W'(b_reg);
         for (int s = 1; s < MUL_LAT - 1; s++) begin
            stage_reg[s] <= stage_reg[s-1];
         end
      end
   end

   assign p = stage_reg[MUL_LAT-2];

endmodule

// File: rtl/polar_clip_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
module polar_clip_mul_arb
   import polar_clip_mul_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = DEF_ID_W,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic             clk,
   input  logic             reset,
   polar_clip_mul_if.slave  bus,
   output logic             busy
);

   logic [ID_W-1:0]          ptr_reg;
   logic [ID_W-1:0]          ptr_next;
   logic [MUL_LAT-1:0]       vld_reg;
   logic [MUL_LAT-1:0]       vld_next;
   logic [ID_W-1:0]          id_reg [MUL_LAT];

   logic                     ce;
   logic                     issue;
   logic                     grant_any;
   logic [NUM_REQ-1:0]       grant;
   logic [ID_W-1:0]          grant_idx;
   logic [ID_W-1:0]          cand;

   logic signed [OP_W-1:0]   op_a [NUM_REQ];
   logic signed [OP_W-1:0]   op_b [NUM_REQ];
   logic signed [OP_W-1:0]   mux_a;
   logic signed [OP_W-1:0]   mux_b;
   logic signed [PROD_W-1:0] prod;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign op_a[gi] = bus.req_a[OP_W*gi +: OP_W];
         assign op_b[gi] = bus.req_b[OP_W*gi +: OP_W];
      end
   endgenerate

   // A presented result that is not taken freezes everything, arbiter included.
   assign ce = !vld_reg[MUL_LAT-1] || bus.res_ready;

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
         if (!grant_any && bus.req_valid[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   assign issue         = ce && grant_any;
   assign bus.req_ready = ce ? grant : '0;
   assign mux_a         = op_a[grant_idx];
   assign mux_b         = op_b[grant_idx];

   always_comb begin
      ptr_next = ptr_reg;
      vld_next = vld_reg;
      if (issue) begin
         ptr_next = ID_W'(rr_next(int'(grant_idx), NUM_REQ));
      end
      if (ce) begin
         vld_next = {vld_reg[MUL_LAT-2:0], issue};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
         vld_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
         vld_reg <= vld_next;
      end
   end

   // Tags travel alongside the multiplier stages; bubbles carry a stale id with valid low.
   always_ff @(posedge clk) begin
      if (ce) begin
         id_reg[0] <= grant_idx;
         for (int s = 1; s < MUL_LAT; s++) begin
            id_reg[s] <= id_reg[s-1];
         end
      end
   end

   polar_clip_mul_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_pipe (
      .clk (clk),
      .ce  (ce),
      .a   (mux_a),
      .b   (mux_b),
      .p   (prod)
   );

   assign bus.res_valid = vld_reg[MUL_LAT-1];
   assign bus.res_id    = id_reg[MUL_LAT-1];
   assign bus.res_data  = prod;
   assign busy          = |vld_reg;

endmodule

// File: tb/tb_polar_clip_mul_arb.sv
// Randomised and directed checks of polar_clip_mul_arb against an in-flight-list model.
module tb_polar_clip_mul_arb;
   import polar_clip_mul_pkg::*;

   localparam int NR  = DEF_NUM_REQ;
   localparam int LAT = DEF_MUL_LAT;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic busy;

   always #5 clk = ~clk;

   polar_clip_mul_if #(.NUM_REQ(NR), .ID_W(DEF_ID_W)) bus ();

   polar_clip_mul_arb #(
      .NUM_REQ (NR),
      .ID_W    (DEF_ID_W),
      .MUL_LAT (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   int checks   = 0;
   int failures = 0;

   logic signed [15:0] a_in [NR];
   logic signed [15:0] b_in [NR];
   logic [NR-1:0]      v_in;

   // Model: accepted products not yet taken, each with the advances left before it is presented.
   typedef struct {
      mul_res_t r;
      int       rem;
   } ent_t;
   ent_t fl[$];
   int   model_ptr;

   logic [NR-1:0] exp_ready, obs_ready;
   logic          exp_valid, obs_valid, exp_busy, obs_busy;
   logic [31:0]   exp_data, obs_data;
   logic [1:0]    exp_id, obs_id;
   int            hs_idx;

   function automatic int rr_pick(input logic [NR-1:0] m, input int p);
      for (int k = 0; k < NR; k++) begin
         if (m[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req_a[16*i +: 16] = a_in[i];
         bus.req_b[16*i +: 16] = b_in[i];
      end
      bus.req_valid = v_in;
   endtask

   // One clock: snapshot DUT outputs before the edge, then advance the model across it.
   task automatic tick();
      int   g;
      logic mce;
      ent_t e;
      drive();
      #2;
      exp_valid = (fl.size() > 0) && (fl[0].rem == 0);
      exp_data  = exp_valid ? fl[0].r.data : 32'h0;
      exp_id    = exp_valid ? fl[0].r.id : 2'd0;
      exp_busy  = (fl.size() > 0);
      mce       = !exp_valid || bus.res_ready;
      g         = mce ? rr_pick(v_in, model_ptr) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      obs_ready = bus.req_ready;
      obs_valid = bus.res_valid;
      obs_data  = bus.res_data;
      obs_id    = bus.res_id;
      obs_busy  = busy;
      @(posedge clk);
      hs_idx = g;
      if (mce) begin
         if (exp_valid) begin
            $display("txn result id=%0d data=%08h", fl[0].r.id, fl[0].r.data);
            void'(fl.pop_front());
         end
         for (int k = 0; k < fl.size(); k++) begin
            e = fl[k];
            if (e.rem > 0) e.rem--;
            fl[k] = e;
         end
         if (g >= 0) begin
            e.r.valid = 1'b1;
            e.r.id    = 2'(g);
            e.r.data  = 32'(int'(a_in[g]) * int'(b_in[g]));
            e.rem     = LAT - 1;
            fl.push_back(e);
            model_ptr = (g + 1) % NR;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v_in  = '0;
      drive();
      @(posedge clk);
      #1;
      reset = 1'b0;
      fl.delete();
      model_ptr = 0;
   endtask

   task automatic test_reset();
      v_in = '0;
      bus.res_ready = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state res_valid=%b busy=%b required 0 0", bus.res_valid, busy);
      end
      reset = 1'b0;
      fl.delete();
      model_ptr = 0;
      tick();
      checks++;
      if (obs_ready !== 4'b0000 || obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle ready=%b valid=%b busy=%b required 0000 0 0", obs_ready, obs_valid, obs_busy);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.res_ready = 1'b1;
      a_in[0] = 16'sd3;
      b_in[0] = -16'sd5;
      v_in = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
         checks++;
         if (obs_valid !== exp_valid) begin
            failures++;
            $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, obs_valid, exp_valid);
         end
         if (c == 0) begin
            checks++;
            if (obs_ready !== 4'b0001) begin
               failures++;
               $display("FAIL single_ready got=%b exp=0001", obs_ready);
            end
         end
         if (c == 3) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== 32'hFFFF_FFF1 || obs_id !== 2'd0) begin
               failures++;
               $display("FAIL single_result valid=%b data=%08h id=%0d exp 1 FFFFFFF1 0", obs_valid, obs_data, obs_id);
            end
         end
         if (c == 4) begin
            checks++;
            if (obs_busy !== 1'b0) begin
               failures++;
               $display("FAIL single_busy got=%b exp=0", obs_busy);
            end
         end
      end
   endtask

   task automatic test_rotation();
      int issued = 0;
      int got = 0;
      logic [3:0] one = 4'b0001;
      do_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         a_in[i] = 16'(i + 1);
         b_in[i] = 16'sd100;
      end
      v_in = 4'b1111;
      for (int c = 0; c < 40 && got < 16; c++) begin
         tick();
         checks++;
         if (obs_ready !== exp_ready || (issued < 16 && obs_ready !== (one << (issued % 4)))) begin
            failures++;
            $display("FAIL rot_grant n=%0d got=%b exp=%b", issued, obs_ready, one << (issued % 4));
         end
         if (got > 0) begin
            checks++;
            if (obs_valid !== 1'b1) begin
               failures++;
               $display("FAIL rot_b2b after=%0d valid=%b exp=1", got, obs_valid);
            end
         end
         if (obs_valid === 1'b1) begin
            checks++;
            if (obs_data !== 32'((got + 1) * 100) || obs_id !== 2'(got % 4)) begin
               failures++;
               $display("FAIL rot_result n=%0d data=%0d id=%0d exp %0d %0d", got, obs_data, obs_id, (got + 1) * 100, got % 4);
            end
            got++;
         end
         if (hs_idx >= 0) begin
            issued++;
            a_in[hs_idx] = a_in[hs_idx] + 16'sd4;
            if (issued + NR - 1 >= 16) v_in[hs_idx] = 1'b0;
         end
      end
      checks++;
      if (got != 16) begin
         failures++;
         $display("FAIL rot_count got=%0d exp=16", got);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hold_data;
      logic [1:0]  hold_id;
      int got = 0;
      do_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         a_in[i] = 16'($urandom);
         b_in[i] = 16'($urandom);
      end
      v_in = 4'b0111;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
      end
      bus.res_ready = 1'b0;
      v_in[3] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c == 0) begin
            hold_data = obs_data;
            hold_id   = obs_id;
         end
         checks++;
         if (obs_valid !== 1'b1 || obs_ready !== 4'b0000 || obs_data !== hold_data || obs_id !== hold_id) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d valid=%b ready=%b data=%08h id=%0d exp 1 0000 %08h %0d",
                     c, obs_valid, obs_ready, obs_data, obs_id, hold_data, hold_id);
         end
         checks++;
         if (obs_data !== exp_data || obs_id !== exp_id) begin
            failures++;
            $display("FAIL stall_value data=%08h id=%0d exp %08h %0d", obs_data, obs_id, exp_data, exp_id);
         end
      end
      bus.res_ready = 1'b1;
      for (int c = 0; c < 10 && got < 4; c++) begin
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
         if (c == 0) begin
            checks++;
            if (obs_ready !== 4'b1000) begin
               failures++;
               $display("FAIL release_issue ready=%b exp=1000", obs_ready);
            end
         end
         if (c < 3) begin
            checks++;
            if (obs_valid !== 1'b1) begin
               failures++;
               $display("FAIL drain_gap cyc=%0d valid=%b exp=1", c, obs_valid);
            end
         end
         if (obs_valid === 1'b1) begin
            checks++;
            if (obs_id !== 2'(got) || obs_data !== exp_data) begin
               failures++;
               $display("FAIL drain_order n=%0d id=%0d data=%08h exp %0d %08h", got, obs_id, obs_data, got, exp_data);
            end
            got++;
         end
      end
      checks++;
      if (got != 4) begin
         failures++;
         $display("FAIL drain_count got=%0d exp=4", got);
      end
   endtask

   task automatic test_corners();
      logic signed [15:0] ca [4];
      logic signed [15:0] cb [4];
      logic [31:0]        cp [4];
      int issued = 0;
      int got = 0;
      ca[0] = -16'sd32768; cb[0] = -16'sd32768; cp[0] = 32'h4000_0000;
      ca[1] =  16'sd32767; cb[1] = -16'sd32768; cp[1] = 32'hC000_8000;
      ca[2] =  16'sd0;     cb[2] = 16'($urandom); cp[2] = 32'h0;
      ca[3] =  16'sd0;     cb[3] = -16'sd1;       cp[3] = 32'h0;
      do_reset();
      bus.res_ready = 1'b1;
      a_in[0] = ca[0];
      b_in[0] = cb[0];
      v_in = 4'b0001;
      for (int c = 0; c < 12 && got < 4; c++) begin
         tick();
         if (obs_valid === 1'b1) begin
            checks++;
            if (obs_data !== cp[got] || obs_data !== exp_data) begin
               failures++;
               $display("FAIL corner n=%0d got=%08h exp=%08h", got, obs_data, cp[got]);
            end
            got++;
         end
         if (hs_idx >= 0) begin
            issued++;
            if (issued < 4) begin
               a_in[0] = ca[issued];
               b_in[0] = cb[issued];
            end else begin
               v_in[0] = 1'b0;
            end
         end
      end
      checks++;
      if (got != 4) begin
         failures++;
         $display("FAIL corner_count got=%0d exp=4", got);
      end
   endtask

   task automatic test_sparse();
      do_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         a_in[i] = 16'($urandom);
         b_in[i] = 16'($urandom);
      end
      v_in = 4'b1010;
      for (int c = 0; c < 14; c++) begin
         if (c == 8) v_in[3] = 1'b0;
         tick();
         checks++;
         if (obs_ready !== exp_ready || obs_ready !== ((c < 8 && c % 2 == 1) ? 4'b1000 : 4'b0010)) begin
            failures++;
            $display("FAIL sparse_grant cyc=%0d got=%b model=%b", c, obs_ready, exp_ready);
         end
         checks++;
         if (obs_valid !== exp_valid || (exp_valid && (obs_data !== exp_data || obs_id !== exp_id))) begin
            failures++;
            $display("FAIL sparse_result cyc=%0d valid=%b data=%08h id=%0d exp %b %08h %0d",
                     c, obs_valid, obs_data, obs_id, exp_valid, exp_data, exp_id);
         end
         if (hs_idx >= 0) begin
            a_in[hs_idx] = 16'($urandom);
            b_in[hs_idx] = 16'($urandom);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         a_in[i] = 16'($urandom);
         b_in[i] = 16'($urandom);
      end
      v_in = 4'b0110;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
      end
      reset = 1'b1;
      v_in = '0;
      drive();
      @(posedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_flush valid=%b busy=%b exp 0 0", bus.res_valid, busy);
      end
      reset = 1'b0;
      fl.delete();
      model_ptr = 0;
      v_in = 4'b1010;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
         if (c == 0) begin
            checks++;
            if (obs_ready !== 4'b0010) begin
               failures++;
               $display("FAIL midreset_ptr ready=%b exp=0010", obs_ready);
            end
         end
         checks++;
         if (obs_valid !== exp_valid || (exp_valid && obs_data !== exp_data)) begin
            failures++;
            $display("FAIL midreset_out cyc=%0d valid=%b data=%08h exp %b %08h", c, obs_valid, obs_data, exp_valid, exp_data);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!v_in[i] && $urandom_range(0, 2) == 0) begin
               v_in[i] = 1'b1;
               a_in[i] = ($urandom_range(0, 7) == 0) ? -16'sd32768 : 16'($urandom);
               b_in[i] = 16'($urandom);
            end
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (hs_idx >= 0) v_in[hs_idx] = 1'b0;
         checks++;
         if (obs_ready !== exp_ready || obs_busy !== exp_busy) begin
            failures++;
            $display("FAIL rand_ctrl cyc=%0d ready=%b busy=%b exp %b %b", c, obs_ready, obs_busy, exp_ready, exp_busy);
         end
         checks++;
         if (obs_valid !== exp_valid || (exp_valid && (obs_data !== exp_data || obs_id !== exp_id))) begin
            failures++;
            $display("FAIL rand_result cyc=%0d valid=%b data=%08h id=%0d exp %b %08h %0d",
                     c, obs_valid, obs_data, obs_id, exp_valid, exp_data, exp_id);
         end
      end
      v_in = '0;
      bus.res_ready = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      checks++;
      if (obs_busy !== 1'b0 || fl.size() != 0) begin
         failures++;
         $display("FAIL rand_drain busy=%b left=%0d exp 0 0", obs_busy, fl.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      v_in = '0;
      for (int i = 0; i < NR; i++) begin
         a_in[i] = '0;
         b_in[i] = '0;
      end
      bus.res_ready = 1'b0;
      model_ptr = 0;
      drive();
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_corners();
      test_sparse();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
